seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised multicycle ALU. Successor to the team's combinational 11-bit ALU.
- Keeps the same 3-bit opcode map and adds the following:
  - generic operand width
  - iterative shift-add multiplier and restoring divider
  - start/done handshake
  - carry and divide-by-zero flags
- Sits between the register file and the writeback mux of the datapath. The controller issues one operation at a time.

Parameters:
WIDTH, 32, operand width in bits (min 4).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; accepted when start && ready
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 nand, 111 clear
ready  output  1  high only in IDLE
done  output  1  one-cycle pulse, result valid
res  output  2*WIDTH  result, held until next done
zeroFlag  output  1  res == 0 over all 2*WIDTH bits, registered with res
carryFlag  output  1  add carry-out / sub borrow; 0 for other ops
dbzFlag  output  1  div with b == 0

Behaviour:
- One clock. Reset is synchronous and active-low. On rst_n == 0 at a rising edge:
  - state becomes IDLE
  - ready = 1 after reset; done = 0
  - res, zeroFlag, carryFlag, dbzFlag = 0
  - internal operand, accumulator and counter registers = 0
- Reset mid-operation aborts the operation silently; no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready = 1.
  - start == 1 at edge T latches a, b and sel.
  - Opcodes 000, 001, 100, 101, 110, 111 and div-by-zero: result computed at T, state moves to DONE, done = 1 during cycle T+1.
  - mul (010) and div (011) with b != 0: state moves to CALC with counter = WIDTH.
- CALC:
  - one iteration per cycle; counter decrements.
  - at counter == 1 the result is written and state moves to DONE.
  - done = 1 during cycle T+WIDTH+1.
- DONE: done = 1 for exactly one cycle, then IDLE. ready = 0 in CALC and DONE.
- start is ignored when ready == 0: no queuing, and latched operands are not disturbed.
- Max throughput is one op per 2 cycles for single-cycle ops.
- Arithmetic:
  - add: res[WIDTH-1:0] = a+b mod 2^WIDTH; carryFlag = bit WIDTH of the sum.
  - sub: res[WIDTH-1:0] = a-b mod 2^WIDTH; carryFlag = (a < b) unsigned.
  - mul: res = full unsigned 2*WIDTH product.
  - div: res[WIDTH-1:0] = unsigned quotient; res[2*WIDTH-1:WIDTH] = remainder.
  - div with b == 0: quotient all ones, remainder = a, dbzFlag = 1, single-cycle latency.
  - and/or/nand: bitwise on WIDTH bits.
  - clear (111): res = 0, zeroFlag = 1.
  - Every op except mul and div forces res[2*WIDTH-1:WIDTH] = 0. nand upper bits are 0, not 1.
- Flags not applicable to the current op are 0.
- res and flags update only on the edge that raises done, and hold between operations.

Optional Feature:
- Macro: SEQ_ALU_EARLY_TERM_EN.
- With the macro defined:
  - mul leaves CALC as soon as the remaining (shifted) multiplier bits are all zero.
  - mul with b == 0 or a == 0 completes in single-cycle latency (done at T+1).
  - mul latency = T + (index of the highest set bit of b) + 2.
  - div is unchanged.
- Without the macro, mul always takes WIDTH iterations (done at T+WIDTH+1).
- Results are bit-identical in both builds.

Test Plan:
- Reset, WIDTH=8: hold rst_n=0 for 2 cycles mid-mul -> ready=1, done=0, res=0, all flags 0, and no done afterwards.
- add a=8'hF0, b=8'h20 -> done at T+1, res=16'h0010, carryFlag=1, zeroFlag=0. sub a=5, b=5 -> res=0, zeroFlag=1, carryFlag=0.
- mul a=8'hFF, b=8'hFF -> done at T+9, res=16'hFE01. With SEQ_ALU_EARLY_TERM_EN, b=8'h03 -> done at T+3, res=16'h02FD.
- div a=100, b=7 -> done at T+9, res={8'd2, 8'd14}. div a=9, b=0 -> done at T+1, res={8'd9, 8'hFF}, dbzFlag=1.
- nand a=8'hFF, b=8'h0F -> res=16'h00F0. clear -> res=0, zeroFlag=1.
- Pulse start again while busy with different operands during a div -> ignored, original div result returned, ready low until after done.

Source files
------------

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/add/sub, iterative shift-add multiply and restoring divide.
// Define SEQ_ALU_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           sel,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   res,
    output logic                 zeroFlag,
    output logic                 carryFlag,
    output logic                 dbzFlag
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned RES_W = 2 * WIDTH;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;     // multiplier (shifted right) or divisor
    logic [RES_W-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [RES_W-1:0]   acc_q, acc_d;       // product, or {remainder, dividend/quotient}
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               dbz_q, dbz_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [RES_W-1:0]   mul_acc_nx;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [RES_W-1:0]   div_acc_nx;
    logic               mul_last;
    logic               calc_last;

    logic               load_res;
    logic [RES_W-1:0]   res_new;
    logic               carry_new;
    logic               dbz_new;

    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = {1'b0, a} - {1'b0, b};

    // One shift-add multiply step and one restoring divide step.
    assign mul_acc_nx = acc_q + (mplr_q[0] ? mcand_q : {RES_W{1'b0}});
    assign rem_sh     = acc_q[RES_W-1:WIDTH-1];
    assign div_diff   = rem_sh - {1'b0, mplr_q};
    assign div_ge     = ~div_diff[WIDTH];
    assign rem_nx     = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_acc_nx = {rem_nx, acc_q[WIDTH-2:0], div_ge};

    assign calc_last = (cnt_q == CNT_W'(1));
`ifdef SEQ_ALU_EARLY_TERM_EN
    assign mul_last = calc_last || (mplr_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    assign mul_last = calc_last;
`endif

    // Next-state, datapath and result-load logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        dbz_d     = dbz_q;
        load_res  = 1'b0;
        res_new   = {RES_W{1'b0}};
        carry_new = 1'b0;
        dbz_new   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d = sel;
                    cnt_d = CNT_W'(WIDTH);
                    case (sel)
                        OP_ADD: begin
                            load_res  = 1'b1;
                            res_new   = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                            carry_new = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            load_res  = 1'b1;
                            res_new   = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                            carry_new = sub_diff[WIDTH];
                        end
                        OP_MUL: begin
                            mcand_d = {{WIDTH{1'b0}}, a};
                            mplr_d  = b;
                            acc_d   = {RES_W{1'b0}};
                            state_d = S_CALC;
`ifdef SEQ_ALU_EARLY_TERM_EN
                            if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
                                load_res = 1'b1;
                            end
`endif
                        end
                        OP_DIV: begin
                            if (b == {WIDTH{1'b0}}) begin
                                load_res = 1'b1;
                                res_new  = {a, {WIDTH{1'b1}}};
                                dbz_new  = 1'b1;
                            end else begin
                                mplr_d  = b;
                                acc_d   = {{WIDTH{1'b0}}, a};
                                state_d = S_CALC;
                            end
                        end
                        OP_AND: begin
                            load_res = 1'b1;
                            res_new  = {{WIDTH{1'b0}}, a & b};
                        end
                        OP_OR: begin
                            load_res = 1'b1;
                            res_new  = {{WIDTH{1'b0}}, a | b};
                        end
                        OP_NAND: begin
                            load_res = 1'b1;
                            res_new  = {{WIDTH{1'b0}}, ~(a & b)};
                        end
                        OP_CLR: begin
                            load_res = 1'b1;
                        end
                        default: begin
                            load_res = 1'b1;
                        end
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (sel_q == OP_MUL) begin
                    acc_d   = mul_acc_nx;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    if (mul_last) begin
                        load_res = 1'b1;
                        res_new  = mul_acc_nx;
                    end
                end else begin
                    acc_d = div_acc_nx;
                    if (calc_last) begin
                        load_res = 1'b1;
                        res_new  = div_acc_nx;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_res) begin
            state_d = S_DONE;
            res_d   = res_new;
            zero_d  = (res_new == {RES_W{1'b0}});
            carry_d = carry_new;
            dbz_d   = dbz_new;
        end
    end

    assign ready_d = (state_d == S_IDLE);
    assign done_d  = (state_d == S_DONE);

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 3'b000;
            mplr_q  <= {WIDTH{1'b0}};
            mcand_q <= {RES_W{1'b0}};
            acc_q   <= {RES_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            res_q   <= {RES_W{1'b0}};
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign res       = res_q;
    assign zeroFlag  = zero_q;
    assign carryFlag = carry_q;
    assign dbzFlag   = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): arithmetic reference model checked every cycle plus literal vectors.
module tb_seq_alu;

    localparam int unsigned W = 8;
`ifdef SEQ_ALU_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     sel = 3'b000;
    logic           ready;
    logic           done;
    logic [2*W-1:0] res;
    logic           zeroFlag;
    logic           carryFlag;
    logic           dbzFlag;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .ready     (ready),
        .done      (done),
        .res       (res),
        .zeroFlag  (zeroFlag),
        .carryFlag (carryFlag),
        .dbzFlag   (dbzFlag)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 done pulse.
    int             m_phase = 0;
    int             m_left = 0;
    logic [2*W-1:0] m_res = '0;
    logic           m_z = 1'b0, m_c = 1'b0, m_d = 1'b0;
    logic [2*W-1:0] p_res;
    logic           p_c, p_d;

    function automatic int hi_bit(input logic [W-1:0] v);
        int h = -1;
        for (int i = 0; i < int'(W); i++) if (v[i]) h = i;
        return h;
    endfunction

    // Returns extra clock edges after acceptance before done rises.
    function automatic int model_op(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                    output logic [2*W-1:0] r, output logic c, output logic d);
        int ai = int'(av);
        int bi = int'(bv);
        int m  = 1 << W;
        int v  = 0;
        int lat = 0;
        c = 1'b0;
        d = 1'b0;
        case (s)
            3'd0: begin v = (ai + bi) % m; c = ((ai + bi) >= m); end
            3'd1: begin v = (ai - bi + m) % m; c = (ai < bi); end
            3'd2: begin
                v = ai * bi;
                if (!ET) lat = W;
                else if (ai == 0 || bi == 0) lat = 0;
                else lat = hi_bit(bv) + 1;
            end
            3'd3: begin
                if (bi == 0) begin v = ai * m + (m - 1); d = 1'b1; end
                else begin v = (ai % bi) * m + (ai / bi); lat = W; end
            end
            3'd4: v = ai & bi;
            3'd5: v = ai | bi;
            3'd6: v = (~(ai & bi)) & (m - 1);
            default: v = 0;
        endcase
        r = (2*W)'(v);
        return lat;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_res = '0; m_z = 1'b0; m_c = 1'b0; m_d = 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_left = model_op(sel, a, b, p_res, p_c, p_d);
                    if (m_left == 0) begin
                        m_res = p_res; m_z = (p_res == '0); m_c = p_c; m_d = p_d;
                        m_phase = 2;
                    end else m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_res = p_res; m_z = (p_res == '0); m_c = p_c; m_d = p_d;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(ready), 32'(m_phase == 0));
            check("done", 32'(done), 32'(m_phase == 2));
            check("res", 32'(res), 32'(m_res));
            check("zeroFlag", 32'(zeroFlag), 32'(m_z));
            check("carryFlag", 32'(carryFlag), 32'(m_c));
            check("dbzFlag", 32'(dbzFlag), 32'(m_d));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] er, input int el, input bit ec, input bit ed);
        int n = 0;
        wait_ready();
        start = 1'b1; sel = s; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check({nm, "_latency"}, 32'(n), 32'(el));
        check({nm, "_res"}, 32'(res), 32'(er));
        check({nm, "_zero"}, 32'(zeroFlag), 32'(er == '0));
        check({nm, "_carry"}, 32'(carryFlag), 32'(ec));
        check({nm, "_dbz"}, 32'(dbzFlag), 32'(ed));
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_res", 32'(res), 32'd0);

        run_op("add",    3'd0, 8'hF0, 8'h20, 16'h0010, 0, 1'b1, 1'b0);
        run_op("sub_eq", 3'd1, 8'd5,  8'd5,  16'h0000, 0, 1'b0, 1'b0);
        run_op("sub_bw", 3'd1, 8'd3,  8'd5,  16'h00FE, 0, 1'b1, 1'b0);
        run_op("mul_ff", 3'd2, 8'hFF, 8'hFF, 16'hFE01, 8, 1'b0, 1'b0);
        run_op("mul_03", 3'd2, 8'hFF, 8'h03, 16'h02FD, ET ? 2 : 8, 1'b0, 1'b0);
        run_op("mul_b0", 3'd2, 8'h12, 8'h00, 16'h0000, ET ? 0 : 8, 1'b0, 1'b0);
        run_op("mul_a0", 3'd2, 8'h00, 8'h05, 16'h0000, ET ? 0 : 8, 1'b0, 1'b0);
        run_op("mul_80", 3'd2, 8'h80, 8'h80, 16'h4000, 8, 1'b0, 1'b0);
        run_op("div",    3'd3, 8'd100, 8'd7, 16'h020E, 8, 1'b0, 1'b0);
        run_op("div_bz", 3'd3, 8'd9,  8'd0,  16'h09FF, 0, 1'b0, 1'b1);
        run_op("div_ff", 3'd3, 8'hFF, 8'h01, 16'h00FF, 8, 1'b0, 1'b0);
        run_op("and",    3'd4, 8'hAA, 8'h0F, 16'h000A, 0, 1'b0, 1'b0);
        run_op("or",     3'd5, 8'hA0, 8'h05, 16'h00A5, 0, 1'b0, 1'b0);
        run_op("nand",   3'd6, 8'hFF, 8'h0F, 16'h00F0, 0, 1'b0, 1'b0);
        run_op("clear",  3'd7, 8'h55, 8'h33, 16'h0000, 0, 1'b0, 1'b0);

        // start while busy with a divide must be ignored
        wait_ready();
        start = 1'b1; sel = 3'd3; a = 8'd200; b = 8'd9;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        check("busy_ready", 32'(ready), 32'd0);
        start = 1'b1; sel = 3'd2; a = 8'h03; b = 8'h04;
        @(negedge clk); n++;
        start = 1'b0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("busy_latency", 32'(n), 32'd8);
        check("busy_res", 32'(res), 32'h0216);
        @(negedge clk);

        // reset in the middle of a multiply
        wait_ready();
        start = 1'b1; sel = 3'd2; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res", 32'(res), 32'd0);
        check("mid_rst_flags", 32'({zeroFlag, carryFlag, dbzFlag}), 32'd0);
        repeat (12) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end

        run_op("post_rst_add", 3'd0, 8'hFF, 8'h01, 16'h0000, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
